// File: rtl/if_stage_sync_rom_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encodings, bus widths and the next-pc helper.
package if_stage_sync_rom_pkg;

  localparam int IF_ID_BUS_W   = 64;
  localparam int JBR_BUS_W     = 33;
  localparam int JBR_TAKEN_BIT = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DONE = 2'd2
  } if_state_t;

  // Branch/jump target when taken, else the sequential pc (mod 2^32).
  function automatic logic [31:0] next_pc(
    input logic [31:0]          pc,
    input logic [JBR_BUS_W-1:0] jbr
  );
    return jbr[JBR_TAKEN_BIT] ? jbr[31:0] : pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_stage_sync_rom_pc_gen.sv
// Program counter register with next-pc selection.
// Loads RESET_PC on reset and advances on each next_fetch pulse.
module if_pc_gen
  import if_stage_sync_rom_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 next_fetch,
  input  logic [JBR_BUS_W-1:0] jbr_bus,
  output logic [31:0]          pc
);

  // pc register: reset value, else advance on next_fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (next_fetch) begin
      pc <= next_pc(pc, jbr_bus);
    end
  end

endmodule

// File: rtl/if_stage_sync_rom.sv
// Fetch stage: drives the sync ROM, waits ROM_LAT, hands {pc,inst}
// to decode. Optional IF_ALIGN_CHK_EN flags misaligned fetches.
module if_stage_sync_rom
  import if_stage_sync_rom_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ROM_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IF_valid,
  input  logic                   next_fetch,
  input  logic [JBR_BUS_W-1:0]   jbr_bus,
  input  logic [31:0]            inst,
  output logic [31:0]            inst_addr,
  output logic                   IF_over,
  output logic [IF_ID_BUS_W-1:0] IF_ID_bus,
  output logic [31:0]            IF_pc,
  output logic [31:0]            IF_inst
`ifdef IF_ALIGN_CHK_EN
  ,
  output logic                   addr_err
`endif
);

  localparam logic [2:0] LAT = 3'(ROM_LAT);

  logic [31:0] pc;
  logic [31:0] inst_r;
  logic [31:0] inst_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  if_state_t   state;
  if_state_t   state_nxt;

`ifdef IF_ALIGN_CHK_EN
  logic misal;
  logic err_r;
  logic err_nxt;
  assign misal    = |pc[1:0];
  assign addr_err = err_r;
`endif

  if_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .reset     (reset),
    .next_fetch(next_fetch),
    .jbr_bus   (jbr_bus),
    .pc        (pc)
  );

  assign inst_addr = pc;
  assign IF_over   = (state == IF_DONE) & IF_valid;
  assign IF_ID_bus = {pc, inst_r};
  assign IF_pc     = pc;
  assign IF_inst   = inst_r;

  // Fetch FSM next state, wait counter and capture
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inst_nxt  = inst_r;
`ifdef IF_ALIGN_CHK_EN
    err_nxt   = err_r;
`endif
    unique case (state)
      IF_IDLE: begin
        if (IF_valid) begin
`ifdef IF_ALIGN_CHK_EN
          if (misal) begin
            state_nxt = IF_DONE;
            inst_nxt  = 32'h0;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = IF_WAIT;
            cnt_nxt   = LAT;
          end
`else
          state_nxt = IF_WAIT;
          cnt_nxt   = LAT;
`endif
        end
      end
      IF_WAIT: begin
        // a pc change mid-wait restarts the ROM read
        if (next_fetch) begin
          cnt_nxt = LAT;
        end else if (!IF_valid) begin
          state_nxt = IF_IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt == 3'd1) begin
          state_nxt = IF_DONE;
          cnt_nxt   = 3'd0;
          inst_nxt  = inst;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      IF_DONE: begin
        if (!IF_valid) begin
          state_nxt = IF_IDLE;
`ifdef IF_ALIGN_CHK_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      default: state_nxt = IF_IDLE;
    endcase
  end

  // FSM, counter and instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IF_IDLE;
      cnt    <= 3'd0;
      inst_r <= 32'h0;
`ifdef IF_ALIGN_CHK_EN
      err_r  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      inst_r <= inst_nxt;
`ifdef IF_ALIGN_CHK_EN
      err_r  <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage_sync_rom.sv
// Scoreboard bench for if_stage_sync_rom (ROM_LAT=3).
// Build with IF_ALIGN_CHK_EN to cover the alignment check.
module tb_if_stage_sync_rom;

  localparam int LAT = 3;
`ifdef IF_ALIGN_CHK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct {
    logic [63:0] bus;
    int          cyc;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        IF_valid;
  logic        next_fetch;
  logic [32:0] jbr_bus;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
`ifdef IF_ALIGN_CHK_EN
  logic        addr_err;
`endif

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          armed = 1'b0;
  logic [31:0] ref_pc = 32'h0;
  logic [31:0] last_inst = 32'h0;
  exp_t        q[$];

  if_stage_sync_rom #(
    .RESET_PC(32'h0),
    .ROM_LAT (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IF_valid  (IF_valid),
    .next_fetch(next_fetch),
    .jbr_bus   (jbr_bus),
    .inst      (inst),
    .inst_addr (inst_addr),
    .IF_over   (IF_over),
    .IF_ID_bus (IF_ID_bus),
    .IF_pc     (IF_pc),
    .IF_inst   (IF_inst)
`ifdef IF_ALIGN_CHK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h2401_0001 ^ (a * 32'h9E37_79B9);
  endfunction

  // ROM data follows the address; the DUT owns the wait count
  always_comb inst = rom(inst_addr);

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_nf(input bit tk, input logic [31:0] tg);
    next_fetch = 1'b1;
    jbr_bus    = {tk, tg};
    tick();
    next_fetch = 1'b0;
    jbr_bus    = {1'b0, $urandom};
    ref_pc     = tk ? tg : ref_pc + 32'd4;
  endtask

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // One fetch as the top FSM would run it
  task automatic fetch(input bit restart, input bit nf_done);
    int   t;
    bit   mis;
    exp_t e;
    t        = cyc;
    mis      = ALN && (ref_pc[1:0] != 2'b00);
    IF_valid = 1'b1;
    if (restart && !mis) begin
      tick();
      pulse_nf(1'b0, 32'h0);
      e.bus = {ref_pc, rom(ref_pc)};
      e.cyc = t + 2 + LAT;
      e.err = 1'b0;
      q.push_back(e);
      repeat (LAT) tick();
    end else begin
      e.bus = {ref_pc, mis ? 32'h0 : rom(ref_pc)};
      e.cyc = mis ? t + 1 : t + 1 + LAT;
      e.err = mis;
      q.push_back(e);
      repeat (mis ? 1 : LAT + 1) tick();
    end
    last_inst = e.bus[31:0];
    if (nf_done) begin
      pulse_nf($urandom_range(1), rnd_target());
      e.bus = {ref_pc, last_inst};
      e.cyc = cyc;
      q.push_back(e);
    end
    tick();
    IF_valid = 1'b0;
    tick();
  endtask

  // Monitor: address every cycle, bus contents on each IF_over
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      chk("inst_addr", {32'h0, inst_addr}, {32'h0, ref_pc});
      if (IF_over === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_IF_over", {63'h0, IF_over}, 64'h0);
        end else begin
          e = q.pop_front();
          chk("IF_ID_bus", IF_ID_bus, e.bus);
          chk("IF_over_cycle", 64'(cyc), 64'(e.cyc));
          chk("IF_pc", {32'h0, IF_pc}, {32'h0, e.bus[63:32]});
          chk("IF_inst", {32'h0, IF_inst}, {32'h0, e.bus[31:0]});
`ifdef IF_ALIGN_CHK_EN
          chk("addr_err", {63'h0, addr_err}, {63'h0, e.err});
`endif
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    IF_valid   = 1'b0;
    next_fetch = 1'b0;
    jbr_bus    = 33'h0;
    repeat (3) tick();
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_IF_ID_bus", IF_ID_bus, 64'h0);
    chk("rst_IF_over", {63'h0, IF_over}, 64'h0);
`ifdef IF_ALIGN_CHK_EN
    chk("rst_addr_err", {63'h0, addr_err}, 64'h0);
`endif
    tick();

    fetch(1'b0, 1'b0);
    chk("first_inst", {32'h0, IF_inst}, 64'h2401_0001);

    pulse_nf(1'b0, 32'hDEAD_BEEF);
    chk("pc_seq", {32'h0, IF_pc}, 64'h4);
    pulse_nf(1'b1, 32'h0000_0040);
    chk("pc_jump", {32'h0, inst_addr}, 64'h40);
    fetch(1'b0, 1'b0);

    // abort in WAIT: no IF_over, inst_r untouched
    pulse_nf(1'b0, 32'h0);
    IF_valid = 1'b1;
    tick();
    tick();
    IF_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("abort_keep_inst", {32'h0, IF_inst}, {32'h0, last_inst});

    fetch(1'b1, 1'b0);
    fetch(1'b0, 1'b1);

    // reset while in WAIT at pc 0x20
    pulse_nf(1'b1, 32'h20);
    IF_valid = 1'b1;
    tick();
    reset    = 1'b1;
    IF_valid = 1'b0;
    tick();
    reset     = 1'b0;
    ref_pc    = 32'h0;
    last_inst = 32'h0;
    chk("rstwait_pc", {32'h0, inst_addr}, 64'h0);
    chk("rstwait_inst", {32'h0, IF_inst}, 64'h0);
    chk("rstwait_over", {63'h0, IF_over}, 64'h0);
    tick();
    fetch(1'b0, 1'b0);

    // pc wrap
    pulse_nf(1'b1, 32'hFFFF_FFFC);
    fetch(1'b0, 1'b0);
    pulse_nf(1'b0, 32'h1234_5678);
    chk("pc_wrap", {32'h0, IF_pc}, 64'h0);
    fetch(1'b0, 1'b0);

    // misaligned target
    pulse_nf(1'b1, 32'h42);
    fetch(1'b0, 1'b0);
`ifdef IF_ALIGN_CHK_EN
    chk("misal_nop", {32'h0, IF_inst}, 64'h0);
`endif
    pulse_nf(1'b1, 32'h100);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(2)) tick();
      if ($urandom_range(1) != 0)
        pulse_nf($urandom_range(1), rnd_target());
      fetch($urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    repeat (4) tick();
    chk("pending_fetches", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
